// File: rtl/alu_req_sequencer.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Define ALU_SEQ_PERF_EN to build the saturating per-requester grant counters.
module alu_req_sequencer #(
  parameter int WIDTH = 7,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [3:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       rsp1_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opsel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             busy,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q;
  logic             lastGrant_q;
  logic             owner_q;
  logic [WIDTH-1:0] aluA_q, aluB_q;
  logic [OPW-1:0]   aluOp_q;
  logic [WIDTH-1:0] result0_q, result1_q;
  logic [3:0]       flags0_q, flags1_q;
  logic             rsp0Valid_q, rsp1Valid_q;

  logic gnt0, gnt1, inIdle, acc0, acc1;

  // On a tie the requester that did not win last time gets the grant.
  assign gnt0   = req0_valid & (~req1_valid | lastGrant_q);
  assign gnt1   = req1_valid & (~req0_valid | ~lastGrant_q);
  assign inIdle = (state_q == IDLE) & ~rst;

  assign req0_ready = inIdle & gnt0;
  assign req1_ready = inIdle & gnt1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_opsel   = aluOp_q;
  assign rsp0_valid  = rsp0Valid_q;
  assign rsp1_valid  = rsp1Valid_q;
  assign rsp0_result = result0_q;
  assign rsp1_result = result1_q;
  assign rsp0_flags  = flags0_q;
  assign rsp1_flags  = flags1_q;
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      result0_q   <= '0;
      result1_q   <= '0;
      flags0_q    <= '0;
      flags1_q    <= '0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc0) begin
            aluA_q      <= req0_a;
            aluB_q      <= req0_b;
            aluOp_q     <= req0_op;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b0;
            state_q     <= EXEC;
          end else if (acc1) begin
            aluA_q      <= req1_a;
            aluB_q      <= req1_b;
            aluOp_q     <= req1_op;
            owner_q     <= 1'b1;
            lastGrant_q <= 1'b1;
            state_q     <= EXEC;
          end
        end
        // ALU output has had a full cycle to settle on the registered operands.
        EXEC: begin
          if (!owner_q) begin
            result0_q   <= alu_result;
            flags0_q    <= {alu_neg, alu_zero, alu_ovf, alu_carry};
            rsp0Valid_q <= 1'b1;
          end else begin
            result1_q   <= alu_result;
            flags1_q    <= {alu_neg, alu_zero, alu_ovf, alu_carry};
            rsp1Valid_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (!owner_q && rsp0_ready) begin
            rsp0Valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (owner_q && rsp1_ready) begin
            rsp1Valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [15:0] gntCnt0_q, gntCnt1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gntCnt0_q <= '0;
      gntCnt1_q <= '0;
    end else begin
      if (acc0 && gntCnt0_q != 16'hFFFF) gntCnt0_q <= gntCnt0_q + 16'd1;
      if (acc1 && gntCnt1_q != 16'hFFFF) gntCnt1_q <= gntCnt1_q + 16'd1;
    end
  end

  assign gnt_cnt0 = gntCnt0_q;
  assign gnt_cnt1 = gntCnt1_q;
`else
  assign gnt_cnt0 = 16'h0000;
  assign gnt_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Scoreboard bench for alu_req_sequencer with a behavioural 7-bit ALU attached.
module tb_alu_req_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [6:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [6:0]  rsp0_result, rsp1_result;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [6:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_opsel;
  logic        alu_carry, alu_ovf, alu_zero, alu_neg;
  logic        busy;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  logic        overrideEn = 1'b0;
  int          checkCount = 0;
  int          errorCount = 0;
  logic [10:0] expQ0[$];
  logic [10:0] expQ1[$];
  logic        grantQ[$];
  int          acc0 = 0;
  int          acc1 = 0;
  logic        aluCheckPending = 1'b0;
  logic [16:0] expAlu;

  alu_req_sequencer #(.WIDTH(7), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .alu_zero(alu_zero), .alu_neg(alu_neg),
    .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;

  // Returns {neg, zero, ovf, carry, result[6:0]}; ovr forces result 0 with flags 0111.
  function automatic logic [10:0] aluModel(input logic [6:0] a, input logic [6:0] b,
                                           input logic [2:0] op, input logic ovr);
    logic [7:0] wide;
    logic [6:0] r;
    logic       c, v;
    wide = 8'd0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      3'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[6:0]; c = wide[7];
        v = (a[6] == b[6]) && (r[6] != a[6]);
      end
      3'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        r = wide[6:0]; c = wide[7];
        v = (a[6] != b[6]) && (r[6] != a[6]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[5:0], 1'b0}; c = a[6]; end
      default: begin r = {1'b0, a[6:1]}; c = a[0]; end
    endcase
    if (ovr) return {1'b0, 1'b1, 1'b1, 1'b1, 7'd0};
    return {r[6], (r == 7'd0), v, c, r};
  endfunction

  always_comb begin
    {alu_neg, alu_zero, alu_ovf, alu_carry, alu_result} = aluModel(alu_a, alu_b, alu_opsel, overrideEn);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: push on command handshake, pop on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (aluCheckPending) begin
        checkOutput("aluOperands", 32'({alu_opsel, alu_b, alu_a}), 32'(expAlu[16:0]));
        aluCheckPending = 1'b0;
      end
      if (req0_valid && req0_ready) begin
        expQ0.push_back(aluModel(req0_a, req0_b, req0_op, overrideEn));
        expAlu = {req0_op, req0_b, req0_a};
        aluCheckPending = 1'b1;
        acc0++;
      end
      if (req1_valid && req1_ready) begin
        expQ1.push_back(aluModel(req1_a, req1_b, req1_op, overrideEn));
        expAlu = {req1_op, req1_b, req1_a};
        aluCheckPending = 1'b1;
        acc1++;
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (grantQ.size() > 0) checkOutput("grantOrder", 32'(req1_ready), 32'(grantQ.pop_front()));
      end
      if (rsp0_valid && rsp0_ready) begin
        if (expQ0.size() == 0) checkOutput("rsp0Spurious", 32'(rsp0_valid), 32'd0);
        else checkOutput("rsp0Data", 32'({rsp0_flags, rsp0_result}), 32'(expQ0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        if (expQ1.size() == 0) checkOutput("rsp1Spurious", 32'(rsp1_valid), 32'd0);
        else checkOutput("rsp1Data", 32'({rsp1_flags, rsp1_result}), 32'(expQ1.pop_front()));
      end
      if (rsp0_valid && rsp1_valid) checkOutput("rspExclusive", 32'(rsp1_valid), 32'd0);
    end
  end

  task automatic randomizeOperands();
    req0_a  = 7'($urandom);
    req0_b  = 7'($urandom);
    req0_op = 3'($urandom);
    req1_a  = 7'($urandom);
    req1_b  = 7'($urandom);
    req1_op = 3'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((busy || expQ0.size() > 0 || expQ1.size() > 0) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) checkOutput("drainTimeout", 32'd0, 32'd1);
  endtask

  // Both requesters contend continuously until n more commands are accepted.
  task automatic applyStimulus(input int n);
    int target;
    int guard = 0;
    target = acc0 + acc1 + n;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    while (acc0 + acc1 < target && guard < 200) begin
      @(posedge clk); #1;
      randomizeOperands();
      guard++;
    end
    if (guard >= 200) checkOutput("opsTimeout", 32'd0, 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
  endtask

  initial begin
    logic [6:0] held;
    int guard;
    rst = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    randomizeOperands();
    #12;
    checkOutput("resetReady", 32'({req0_ready, req1_ready}), 32'd0);
    checkOutput("resetAlu", 32'({alu_opsel, alu_b, alu_a}), 32'd0);
    checkOutput("resetRsp", 32'({rsp0_valid, rsp1_valid, busy}), 32'd0);
    checkOutput("resetData", 32'({rsp0_flags, rsp0_result, rsp1_flags, rsp1_result}), 32'd0);
    checkOutput("resetCnt", 32'({gnt_cnt0, gnt_cnt1}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    grantQ = '{1'b0, 1'b1, 1'b0, 1'b1};
    applyStimulus(4);
    checkOutput("tieGrantsUsed", 32'(grantQ.size()), 32'd0);

    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 7'd5; req0_b = 7'd3; req0_op = 3'd0;
    @(negedge clk);
    checkOutput("singleReadyT", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    checkOutput("singleT1", 32'({busy, rsp0_valid}), 32'b10);
    @(negedge clk);
    checkOutput("singleValidT2", 32'({rsp0_valid, rsp1_valid}), 32'b10);
    checkOutput("singleResult", 32'(rsp0_result), 32'd8);
    checkOutput("singleFlags", 32'(rsp0_flags), 32'd0);
    @(negedge clk);
    checkOutput("singleIdleT3", 32'({busy, rsp0_valid, rsp1_valid}), 32'd0);

    @(posedge clk); #1;
    overrideEn = 1'b1;
    req0_valid = 1'b1; req0_a = 7'd9; req0_b = 7'd2; req0_op = 3'd0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("flagPassValid", 32'(rsp0_valid), 32'd1);
    checkOutput("flagPass", 32'({rsp0_flags, rsp0_result}), 32'({4'b0111, 7'd0}));
    @(posedge clk); #1;
    overrideEn = 1'b0;
    drain();

    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 7'd100; req1_b = 7'd50; req1_op = 3'd1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rsp1_valid && guard < 20);
    if (guard >= 20) checkOutput("bpTimeout", 32'd0, 32'd1);
    held = rsp1_result;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bpStable", 32'({rsp1_valid, rsp1_result}), 32'({1'b1, held}));
      checkOutput("bpBusyReady", 32'({busy, req0_ready}), 32'b10);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bpRelease", 32'({busy, rsp1_valid}), 32'd0);
    drain();

    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 7'd33; req0_b = 7'd44; req0_op = 3'd4;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncAlu", 32'({alu_opsel, alu_b, alu_a}), 32'd0);
    checkOutput("asyncCtl", 32'({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 32'd0);
    checkOutput("asyncData", 32'({rsp0_flags, rsp0_result}), 32'd0);
    expQ0.delete();
    expQ1.delete();
    acc0 = 0;
    acc1 = 0;
    aluCheckPending = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("asyncNoRsp", 32'({rsp0_valid, rsp1_valid, busy}), 32'd0);

    grantQ = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    applyStimulus(5);
    checkOutput("postResetGrantsUsed", 32'(grantQ.size()), 32'd0);
`ifdef ALU_SEQ_PERF_EN
    checkOutput("gntCnt0", 32'(gnt_cnt0), 32'd3);
    checkOutput("gntCnt1", 32'(gnt_cnt1), 32'd2);
`else
    checkOutput("gntCnt0", 32'(gnt_cnt0), 32'd0);
    checkOutput("gntCnt1", 32'(gnt_cnt1), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
